// File: rtl/as_sc_hs_cell_exerciser_pkg.sv
// Shared types and constants for the sky130_as_sc_hs cell exerciser.
//   exer_state_t  : run-sequencer states
//   LFSR_TAPS     : Galois feedback mask of the 16-bit vector LFSR
//   LFSR_DEF_SEED : seed used whenever a zero seed is requested
//   lfsr_next()   : one right-shift Galois step
package as_sc_hs_exer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } exer_state_t;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

  // Galois LFSR: the bit shifted out of position 0 folds the tap mask back in.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    lfsr_next = q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/as_sc_hs_cell_exerciser_if.sv
// Bundle between the config/status register block (master) and the
// exerciser (slave), together with the cell-under-test drive and response.
//   START/MODE/SEED/N_VECT/TT : run request and parameters
//   BUSY/DONE/PASS/ERR_CNT/FIRST_ERR_VEC : run status
//   CUT_IN : drive {D,C,B,A} to the cell, CUT_Y : cell output
interface as_sc_hs_cell_exerciser_if #(
  parameter int unsigned ERR_W = 16
);
  logic             START;
  logic             MODE;
  logic [15:0]      SEED;
  logic [15:0]      N_VECT;
  logic [15:0]      TT;
  logic [3:0]       CUT_IN;
  logic             CUT_Y;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [ERR_W-1:0] ERR_CNT;
  logic [3:0]       FIRST_ERR_VEC;

  modport master (
    output START, MODE, SEED, N_VECT, TT, CUT_Y,
    input  CUT_IN, BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_VEC
  );

  modport slave (
    input  START, MODE, SEED, N_VECT, TT, CUT_Y,
    output CUT_IN, BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_VEC
  );
endinterface

// File: rtl/as_sc_hs_cell_exerciser_lfsr16.sv
// 16-bit Galois LFSR producing pseudo-random cell vectors.
//   CLK, RST : clock, synchronous active-high reset (Q returns to DEF_SEED)
//   LOAD     : take SEED (a zero seed is replaced by DEF_SEED)
//   STEP     : advance one position
//   Q        : current LFSR state
module as_sc_hs_lfsr16
  import as_sc_hs_exer_pkg::*;
#(
  parameter logic [15:0] DEF_SEED = LFSR_DEF_SEED
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [15:0] SEED,
  input  logic        STEP,
  output logic [15:0] Q
);

  logic [15:0] r_q;

  // LFSR state: reset, seed load (zero seed would lock up), or step.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= DEF_SEED;
    end else if (LOAD) begin
      r_q <= (SEED == 16'h0000) ? DEF_SEED : SEED;
    end else if (STEP) begin
      r_q <= lfsr_next(r_q);
    end else begin
      r_q <= r_q;
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/as_sc_hs_cell_exerciser.sv
// Stimulus/response harness for one combinational cell under test.
// Each vector takes APPLY (1) + SETTLE (SETTLE_CYC) + CAPTURE (1) cycles;
// CAPTURE compares CUT_Y against the latched truth table and keeps a
// saturating error count plus the first failing vector.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of as_sc_hs_cell_exerciser_if (run control,
//              status, CUT drive/response)
module as_sc_hs_cell_exerciser
  import as_sc_hs_exer_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned ERR_W      = 16,
  parameter logic [15:0] DEF_SEED   = LFSR_DEF_SEED
) (
  input  logic                       CLK,
  input  logic                       RST,
  as_sc_hs_cell_exerciser_if.slave   bus
);

  localparam int unsigned     SC_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  exer_state_t       r_state;
  logic              r_mode;
  logic [15:0]       r_tt;
  logic [15:0]       r_n_left;
  logic [3:0]        r_cnt;
  logic [3:0]        r_cut_in;
  logic [3:0]        r_first_err;
  logic [SC_W-1:0]   r_settle;
  logic [ERR_W-1:0]  r_err_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic              w_start_acc;
  logic              w_step;
  logic              w_mismatch;
  logic [3:0]        w_vec;
  logic [15:0]       w_lfsr_q;
  logic              w_lfsr_hi_unused;
  logic [ERR_W-1:0]  w_err_next;

  // A START is only honoured when no run is in progress.
  assign w_start_acc = bus.START && ((r_state == IDLE) || (r_state == DONE));
  assign w_step      = (r_state == CAPTURE);
  assign w_vec       = r_mode ? r_cnt : w_lfsr_q[3:0];
  assign w_mismatch  = bus.CUT_Y ^ r_tt[r_cut_in];
  assign w_err_next  = (w_mismatch && (r_err_cnt != ERR_MAX)) ? (r_err_cnt + ERR_W'(1)) : r_err_cnt;
  // Only the low nibble of the LFSR drives the cell.
  assign w_lfsr_hi_unused = ^w_lfsr_q[15:4];

  as_sc_hs_lfsr16 #(
    .DEF_SEED (DEF_SEED)
  ) u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .LOAD (w_start_acc),
    .SEED (bus.SEED),
    .STEP (w_step),
    .Q    (w_lfsr_q)
  );

  // Run sequencer with its counters, comparator state and registered status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_tt        <= 16'h0000;
      r_n_left    <= 16'h0000;
      r_cnt       <= 4'h0;
      r_cut_in    <= 4'h0;
      r_first_err <= 4'h0;
      r_settle    <= {SC_W{1'b0}};
      r_err_cnt   <= {ERR_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_acc) begin
            r_mode      <= bus.MODE;
            r_tt        <= bus.TT;
            r_n_left    <= bus.N_VECT;
            r_cnt       <= 4'h0;
            r_first_err <= 4'h0;
            r_err_cnt   <= {ERR_W{1'b0}};
            if (bus.N_VECT != 16'h0000) begin
              r_state <= APPLY;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end else begin
              // Empty run: completes immediately with nothing to fail.
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end
          end else begin
            r_state <= r_state;
          end
        end
        APPLY: begin
          r_cut_in <= w_vec;
          r_settle <= SC_LOAD;
          r_state  <= SETTLE;
        end
        SETTLE: begin
          if (r_settle == {SC_W{1'b0}}) begin
            r_state <= CAPTURE;
          end else begin
            r_settle <= r_settle - SC_W'(1);
          end
        end
        CAPTURE: begin
          r_err_cnt <= w_err_next;
          if (w_mismatch && (r_err_cnt == {ERR_W{1'b0}})) begin
            r_first_err <= r_cut_in;
          end else begin
            r_first_err <= r_first_err;
          end
          r_n_left <= r_n_left - 16'd1;
          r_cnt    <= r_cnt + 4'd1;
          if (r_n_left > 16'd1) begin
            r_state <= APPLY;
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == {ERR_W{1'b0}});
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CUT_IN        = r_cut_in;
  assign bus.BUSY          = r_busy;
  assign bus.DONE          = r_done;
  assign bus.PASS          = r_pass;
  assign bus.ERR_CNT       = r_err_cnt;
  assign bus.FIRST_ERR_VEC = r_first_err;

endmodule

// File: tb/tb_as_sc_hs_cell_exerciser.sv
// Bench: two exercisers (ERR_W=16 and ERR_W=4) driven identically, each
// wired to a behavioural nand2 on A,B. Expected results come from a
// run-level model (vector list, mismatch tally) and from a hand-filled table.
module tb_as_sc_hs_cell_exerciser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  as_sc_hs_cell_exerciser_if #(.ERR_W(16)) ifa ();
  as_sc_hs_cell_exerciser_if #(.ERR_W(4))  ifb ();

  as_sc_hs_cell_exerciser #(.SETTLE_CYC(2), .ERR_W(16), .DEF_SEED(16'hACE1)) dut_a (
    .CLK (clk), .RST (rst), .bus (ifa)
  );
  as_sc_hs_cell_exerciser #(.SETTLE_CYC(2), .ERR_W(4), .DEF_SEED(16'hACE1)) dut_b (
    .CLK (clk), .RST (rst), .bus (ifb)
  );

  assign ifa.CUT_Y = ~(ifa.CUT_IN[0] & ifa.CUT_IN[1]);
  assign ifb.CUT_Y = ~(ifb.CUT_IN[0] & ifb.CUT_IN[1]);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic mode, input logic [15:0] seed,
                       input logic [15:0] n, input logic [15:0] tt);
    ifa.START = start; ifa.MODE = mode; ifa.SEED = seed; ifa.N_VECT = n; ifa.TT = tt;
    ifb.START = start; ifb.MODE = mode; ifb.SEED = seed; ifb.N_VECT = n; ifb.TT = tt;
  endtask

  // Reference model: list of vectors the run should apply, and its mismatches.
  logic [3:0] m_vecs[$];
  int         m_err;
  logic [3:0] m_first;

  function automatic void model(input logic mode, input logic [15:0] seed,
                                input logic [15:0] n, input logic [15:0] tt);
    int unsigned s;
    int          c;
    logic [3:0]  v;
    logic        y;
    m_vecs.delete();
    m_err   = 0;
    m_first = 4'h0;
    s = (seed == 16'h0000) ? 32'hACE1 : {16'h0000, seed};
    c = 0;
    for (int j = 0; j < int'(n); j++) begin
      v = mode ? 4'(c) : 4'(s % 16);
      m_vecs.push_back(v);
      y = !(v[0] && v[1]);
      if (y != tt[v]) begin
        if (m_err == 0) m_first = v;
        m_err++;
      end
      if (s % 2 == 1) s = (s / 2) ^ 32'hB400;
      else            s = s / 2;
      c = (c + 1) % 16;
    end
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // One complete run: START, per-vector drive checks, BUSY/DONE timing, results.
  task automatic run_check(input string tag, input logic mode, input logic [15:0] seed,
                           input logic [15:0] n, input logic [15:0] tt, input bit disturb,
                           output logic [3:0] first_cut);
    int total;
    int busy_bad;
    model(mode, seed, n, tt);
    total     = 4 * int'(n);
    busy_bad  = 0;
    first_cut = 4'h0;
    drive(1'b1, mode, seed, n, tt);
    tick();
    drive(1'b0, mode, seed, n, tt);
    for (int i = 0; i <= total; i++) begin
      if (disturb && i == 10) drive(1'b1, ~mode, 16'h1234, 16'd3, ~tt);
      if (disturb && i == 11) drive(1'b0, ~mode, 16'h1234, 16'd3, ~tt);
      if (i < total) begin
        if (ifa.BUSY !== 1'b1 || ifb.BUSY !== 1'b1 || ifa.DONE !== 1'b0 || ifb.DONE !== 1'b0)
          busy_bad++;
        if (i % 4 == 3) begin
          chk({tag, " cut_in_a"}, ifa.CUT_IN, m_vecs[i / 4]);
          chk({tag, " cut_in_b"}, ifb.CUT_IN, m_vecs[i / 4]);
          if (i == 3) first_cut = ifa.CUT_IN;
        end
        tick();
      end
    end
    chk({tag, " busy_window"}, busy_bad, 0);
    chk({tag, " done_a"},  ifa.DONE, 1);
    chk({tag, " done_b"},  ifb.DONE, 1);
    chk({tag, " busy_a_end"}, ifa.BUSY, 0);
    chk({tag, " err_a"},   ifa.ERR_CNT, sat(m_err, 16));
    chk({tag, " err_b"},   ifb.ERR_CNT, sat(m_err, 4));
    chk({tag, " first_a"}, ifa.FIRST_ERR_VEC, m_first);
    chk({tag, " first_b"}, ifb.FIRST_ERR_VEC, m_first);
    chk({tag, " pass_a"},  ifa.PASS, (m_err == 0));
    chk({tag, " pass_b"},  ifb.PASS, (m_err == 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cut_in"}, {ifa.CUT_IN, ifb.CUT_IN}, 0);
    chk({tag, " busy"},   {ifa.BUSY, ifb.BUSY}, 0);
    chk({tag, " done"},   {ifa.DONE, ifb.DONE}, 0);
    chk({tag, " pass"},   {ifa.PASS, ifb.PASS}, 0);
    chk({tag, " err_a"},  ifa.ERR_CNT, 0);
    chk({tag, " err_b"},  ifb.ERR_CNT, 0);
    chk({tag, " first"},  {ifa.FIRST_ERR_VEC, ifb.FIRST_ERR_VEC}, 0);
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] seed;
    logic [15:0] n;
    logic [15:0] tt;
    int          exp_err16;
    int          exp_err4;
    logic [3:0]  exp_first;
    logic        exp_pass;
    logic [3:0]  exp_cut0;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [3:0]  fc;
    logic        r_mode;
    logic [15:0] r_seed, r_n, r_tt;

    tbl[0] = '{1'b1, 16'h0000, 16'd16,  16'h7777, 0,   0,  4'h0, 1'b1, 4'h0};
    tbl[1] = '{1'b1, 16'h0000, 16'd16,  16'h7776, 1,   1,  4'h0, 1'b0, 4'h0};
    tbl[2] = '{1'b1, 16'h0000, 16'd20,  16'h7776, 2,   2,  4'h0, 1'b0, 4'h0};
    tbl[3] = '{1'b0, 16'h0000, 16'd100, 16'h8888, 100, 15, 4'h1, 1'b0, 4'h1};
    tbl[4] = '{1'b1, 16'h0000, 16'd0,   16'h7777, 0,   0,  4'h0, 1'b1, 4'h0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) begin
      run_check($sformatf("tbl%0d", k), tbl[k].mode, tbl[k].seed, tbl[k].n, tbl[k].tt, 1'b0, fc);
      chk($sformatf("tbl%0d err16", k), ifa.ERR_CNT, tbl[k].exp_err16);
      chk($sformatf("tbl%0d err4", k),  ifb.ERR_CNT, tbl[k].exp_err4);
      chk($sformatf("tbl%0d first", k), ifa.FIRST_ERR_VEC, tbl[k].exp_first);
      chk($sformatf("tbl%0d pass", k),  ifa.PASS, tbl[k].exp_pass);
      if (tbl[k].n != 16'd0) chk($sformatf("tbl%0d cut0", k), fc, tbl[k].exp_cut0);
      tick();
    end

    // START and input changes during a run must not alter it.
    run_check("busy_start", 1'b1, 16'h0000, 16'd16, 16'h7777, 1'b1, fc);
    tick();

    // Reset in the middle of vector 5 of a failing run.
    drive(1'b1, 1'b1, 16'h0000, 16'd16, 16'h8888);
    tick();
    drive(1'b0, 1'b1, 16'h0000, 16'd16, 16'h8888);
    repeat (23) tick();
    chk("midrun err_before_rst", ifa.ERR_CNT, 5);
    rst = 1'b1;
    tick();
    chk_all_zero("midrun_rst");

    // RST together with START: reset wins, nothing starts.
    drive(1'b1, 1'b1, 16'h0000, 16'd16, 16'h7777);
    tick();
    chk_all_zero("rst_start");
    rst = 1'b0;
    drive(1'b0, 1'b1, 16'h0000, 16'd16, 16'h7777);
    tick();
    chk("rst_start idle_busy", {ifa.BUSY, ifa.DONE}, 0);

    run_check("after_rst", 1'b1, 16'h0000, 16'd16, 16'h7777, 1'b0, fc);
    tick();

    // Randomised runs against the model.
    for (int r = 0; r < 6; r++) begin
      r_mode = 1'($urandom_range(0, 1));
      r_seed = (r == 2) ? 16'h0000 : 16'($urandom);
      r_n    = 16'($urandom_range(0, 40));
      r_tt   = 16'($urandom);
      run_check($sformatf("rand%0d", r), r_mode, r_seed, r_n, r_tt, 1'b0, fc);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
